// File: rtl/capture_base_kf_loader.sv
// capture_base_kf_loader: decodes the toggle-handshaked base_kf command word,
// loads/clears the shadow bank of a double-banked coefficient table, swaps
// banks on frame start, and serves registered per-channel lookups.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for commands; WRITE/COMMIT handled in place
// SWEEP  | CLEAR in progress, one shadow entry written per cycle (busy)
module capture_base_kf_loader #(
  parameter int NCHAN_LOG2 = 8,
  parameter int COEF_W     = 16
) (
  input  logic                  user_clk,
  input  logic                  rst,
  input  logic [31:0]           reg_data,
  input  logic                  sof,
  input  logic [NCHAN_LOG2-1:0] chan,
  output logic [COEF_W-1:0]     coef_out,
  output logic [31:0]           status
);

  localparam int DEPTH = 1 << NCHAN_LOG2;
  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_COMMIT = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;

  typedef enum logic {S_IDLE, S_SWEEP} state_t;

  state_t                  state;
  logic [31:0]             reg_q;
  logic                    reg_vld;
  logic                    armed;
  logic                    last_toggle;
  logic                    toggle_echo;
  logic                    pending;
  logic                    active_bank;
  logic [NCHAN_LOG2-1:0]   sweep_addr;
  logic [COEF_W-1:0]       sweep_data;
  logic [7:0]              err_cnt;
  logic [7:0]              cmd_cnt;

  logic [1:0]              opcode;
  logic [12:0]             addr;
  logic [15:0]             data;
  logic                    busy;
  logic                    swap;
  logic                    pend_eff;
  logic                    bank_eff;
  logic                    cmd_det;
  logic                    addr_hi_bad;
  logic                    accept;

  logic                    we;
  logic [NCHAN_LOG2:0]     waddr;
  logic [COEF_W-1:0]       wdata;

  logic [COEF_W-1:0]       mem [0:2*DEPTH-1];
  logic [NCHAN_LOG2-1:0]   chan_q;
  logic                    bank_q;

  assign opcode      = reg_q[30:29];
  assign addr        = reg_q[28:16];
  assign data        = reg_q[15:0];
  assign busy        = (state == S_SWEEP);
  assign swap        = sof && pending;
  // A command seen on a swap cycle is judged against the post-swap pending.
  assign pend_eff    = pending && !sof;
  assign bank_eff    = active_bank ^ swap;
  assign cmd_det     = armed && (reg_q[31] != last_toggle);
  assign addr_hi_bad = (addr >> NCHAN_LOG2) != 13'd0;

  // Command legality against the current busy / effective pending state.
  always_comb begin
    accept = 1'b0;
    case (opcode)
      OP_WRITE:  accept = !addr_hi_bad && !busy && !pend_eff;
      OP_COMMIT: accept = !busy;
      OP_CLEAR:  accept = !busy && !pend_eff;
      default:   accept = 1'b0;
    endcase
  end

  // Single shadow write port shared by the sweep and single WRITE commands.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (busy) begin
      we    = 1'b1;
      waddr = {~active_bank, sweep_addr};
      wdata = sweep_data;
    end else if (cmd_det && accept && (opcode == OP_WRITE)) begin
      we    = 1'b1;
      waddr = {~bank_eff, addr[NCHAN_LOG2-1:0]};
      wdata = data[COEF_W-1:0];
    end
  end

  // Command sequencer: input stage, toggle handshake, bank swap and sweep FSM.
  always_ff @(posedge user_clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      reg_q       <= '0;
      reg_vld     <= 1'b0;
      armed       <= 1'b0;
      last_toggle <= 1'b0;
      toggle_echo <= 1'b0;
      pending     <= 1'b0;
      active_bank <= 1'b0;
      sweep_addr  <= '0;
      sweep_data  <= '0;
      err_cnt     <= '0;
      cmd_cnt     <= '0;
    end else begin
      reg_q   <= reg_data;
      reg_vld <= 1'b1;
      // Absorb whatever toggle is already present so a stale word never replays.
      if (reg_vld && !armed) begin
        armed       <= 1'b1;
        last_toggle <= reg_q[31];
      end
      if (swap) begin
        active_bank <= ~active_bank;
        pending     <= 1'b0;
      end
      if (cmd_det) begin
        last_toggle <= reg_q[31];
        if (accept) begin
          cmd_cnt     <= cmd_cnt + 8'd1;
          toggle_echo <= reg_q[31];
          if (opcode == OP_COMMIT) begin
            pending <= 1'b1;
          end else if (opcode == OP_CLEAR) begin
            state      <= S_SWEEP;
            sweep_addr <= '0;
            sweep_data <= data[COEF_W-1:0];
          end
        end else if (err_cnt != 8'hFF) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end
      if (state == S_SWEEP) begin
        sweep_addr <= sweep_addr + 1'b1;
        if (sweep_addr == '1) begin
          state <= S_IDLE;
        end
      end
    end
  end

  // Readback word, one cycle behind the control registers.
  always_ff @(posedge user_clk or posedge rst) begin
    if (rst) begin
      status <= '0;
    end else begin
      status <= {busy, pending, active_bank, toggle_echo, 12'd0, err_cnt, cmd_cnt};
    end
  end

  // Coefficient RAM write port (contents are not reset).
  always_ff @(posedge user_clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Lookup pipeline: register chan and bank, then a registered RAM read.
  always_ff @(posedge user_clk or posedge rst) begin
    if (rst) begin
      chan_q   <= '0;
      bank_q   <= 1'b0;
      coef_out <= '0;
    end else begin
      chan_q   <= chan;
      bank_q   <= bank_eff;
      coef_out <= mem[{bank_q, chan_q}];
    end
  end

endmodule

// File: doc/capture_base_kf_loader.md
# capture_base_kf_loader

Sequencer for the capture-path baseline filter coefficient table, running in the user clock domain downstream of the capture1 base_kf software register. It decodes the 32-bit command word written by the PPC, loads or bulk-clears a double-banked per-channel coefficient RAM, and swaps banks only on a frame boundary so the datapath never sees a partially updated table. A status word is exported for a readback register so software can handshake each command.

## Interface

- NCHAN_LOG2, 8: log2 of channel count; table depth 2^NCHAN_LOG2 per bank
- COEF_W, 16: coefficient width; must be 16 or less
- user_clk  in  1  user/datapath clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- reg_data  in  32  software register output (command word)
- sof  in  1  start-of-frame strobe, high on the cycle chan=0 of each frame
- chan  in  NCHAN_LOG2  datapath channel index for coefficient lookup
- coef_out  out  COEF_W  coefficient for chan, from active bank
- status  out  32  readback word for a simulink2ppc register

## Operation

- Command word: [31] toggle; [30:29] opcode; [28:16] address; [15:0] data.
- Opcodes: 00 WRITE shadow[addr]=data[COEF_W-1:0]; 01 COMMIT (request bank swap); 10 CLEAR (fill every shadow entry with data); 11 illegal.
- reg_data is registered once (input stage). A command is detected when registered bit31 differs from last_toggle.
- First cycle after reset release: last_toggle loads registered bit31 without executing. This prevents replay of a stale command.
- Accepted command: last_toggle updates, cmd_cnt increments, and execution proceeds as below.
- Rejected command: last_toggle still updates, so the command is consumed once. err_cnt increments and the toggle echo is not updated.
- Rejection causes: opcode 11; address bits above NCHAN_LOG2 nonzero on WRITE; WRITE or CLEAR while busy or commit_pending; COMMIT while busy.
- COMMIT while commit_pending=1 is accepted as a no-op.
- FSM states:
  - IDLE: accept WRITE (single RAM write, stay IDLE), COMMIT (set commit_pending, stay IDLE), CLEAR (go to SWEEP).
  - SWEEP: write shadow[k]=data for k=0..2^NCHAN_LOG2-1, one entry per cycle, busy=1. After the last address, return to IDLE.
- Shadow bank is always ~active_bank.
- Bank swap: on any cycle with sof=1 and commit_pending=1, active_bank toggles and commit_pending clears. The lookup for chan on that same cycle already uses the new bank.
- Lookup: chan and bank select are registered, followed by a registered RAM read.
- status:
  - [31] busy
  - [30] commit_pending
  - [29] active_bank
  - [28] toggle echo (bit31 of last accepted command)
  - [27:16] zero
  - [15:8] err_cnt, saturating at 255
  - [7:0] cmd_cnt, wrapping

## Timing

- Reset values: coef_out=0, status=0, active_bank=0, pending=0, busy=0, state IDLE, counters 0.
- RAM contents are not reset. Software clears both banks after reset.
- Command latency: reg_data changes at cycle 0; detection at cycle 1; RAM write or pending set at cycle 2; status updated at cycle 3.
- CLEAR: busy rises at cycle 2 and is held for exactly 2^NCHAN_LOG2 cycles.
- Lookup latency: coef_out reflects chan presented at cycle n at cycle n+2. Throughput is one lookup per cycle.
- A new command arriving in the same cycle the FSM leaves SWEEP is evaluated against busy=1 and rejected.
- A command detection coinciding with a swap is evaluated against the post-swap pending=0.
- Reset mid-SWEEP or mid-pending aborts immediately. Partially written shadow contents are undefined.

## Test plan

- Reset, then CLEAR data=0x0000 (toggle 1), wait busy=0, COMMIT (toggle 0), pulse sof, CLEAR data=0x0000 (toggle 1), COMMIT -> both banks zero, coef_out=0 for all chan, cmd_cnt=4, err_cnt=0, active_bank=0 after second swap.
- WRITE addr 5 = 0x1234, COMMIT, sweep chan 0..255 with sof at chan 0 -> coef_out=0x1234 two cycles after chan=5 only in frames after sof, status[29] toggled, [30] drops on sof cycle.
- WRITE issued while commit_pending=1 -> err_cnt=1, toggle echo unchanged, shadow unmodified.
- CLEAR data=0xBEEF followed one cycle later by WRITE addr 3 -> WRITE rejected (busy), all 256 entries 0xBEEF after commit, busy high exactly 256 cycles.
- Opcode 11 and WRITE addr 0x100 with NCHAN_LOG2=8 -> err_cnt=2, no RAM change; 300 illegal commands -> err_cnt holds at 255.
- reg_data bit31=1 held through reset release -> no command executed, cmd_cnt=0. Assert rst mid-SWEEP -> busy=0, coef_out=0 asynchronously.
